// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one bit per clock.
// Optional macro BCD_EXCESS3_OUT_EN: latch digits as excess-3 instead of BCD.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out,
  output logic                  busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  function automatic bit range_ok();
    longint p;
    longint m;
    p = 1;
    for (int i = 0; i < DIGITS; i++) p = p * 10;
    m = (longint'(1) << BIN_W) - 1;
    return (BCD_W >= BIN_W) && (p > m);
  endfunction

  generate
    if (!range_ok()) begin : g_bad_params
      $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [SR_W-1:0]  sr;
  logic [SR_W-1:0]  adj;
  logic [SR_W-1:0]  shifted;
  logic [BCD_W-1:0] res;
  logic [CNT_W-1:0] cnt;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (in_valid) state_nx = SHIFT;
      SHIFT: if (cnt == CNT_W'(1)) state_nx = DONE;
      DONE:  if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // per-nibble add-3 correction, then shift left by one
  always_comb begin
    adj = sr;
    for (int d = 0; d < DIGITS; d++) begin
      if (sr[BIN_W+4*d +: 4] >= 4'd5)
        adj[BIN_W+4*d +: 4] = sr[BIN_W+4*d +: 4] + 4'd3;
    end
    shifted = {adj[SR_W-2:0], 1'b0};
  end

  // result formatting at latch time
  always_comb begin
    res = shifted[SR_W-1 -: BCD_W];
`ifdef BCD_EXCESS3_OUT_EN
    for (int d = 0; d < DIGITS; d++)
      res[4*d +: 4] = shifted[BIN_W+4*d +: 4] + 4'd3;
`endif
  end

  // shift register, bit counter and output latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
      out <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sr  <= {{BCD_W{1'b0}}, in};
            cnt <= CNT_W'(BIN_W);
          end
        end
        SHIFT: begin
          sr  <= shifted;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) out <= res;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE) & rst_n;
  assign out_valid = (state == DONE);
  assign busy      = (state == SHIFT) | (state == DONE);

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq.
// Expected results switch with BCD_EXCESS3_OUT_EN.
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out;
  logic        busy;

  int checks;
  int failures;

`ifdef BCD_EXCESS3_OUT_EN
  localparam logic [11:0] E0   = 12'h333;
  localparam logic [11:0] E255 = 12'h588;
  localparam logic [11:0] E9   = 12'h33C;
  localparam logic [11:0] E100 = 12'h433;
  localparam logic [11:0] E99  = 12'h3CC;
  localparam logic [11:0] E42  = 12'h375;
  localparam logic [11:0] E17  = 12'h34A;
  localparam logic [11:0] E5   = 12'h338;
  localparam logic [11:0] E47  = 12'h37A;
`else
  localparam logic [11:0] E0   = 12'h000;
  localparam logic [11:0] E255 = 12'h255;
  localparam logic [11:0] E9   = 12'h009;
  localparam logic [11:0] E100 = 12'h100;
  localparam logic [11:0] E99  = 12'h099;
  localparam logic [11:0] E42  = 12'h042;
  localparam logic [11:0] E17  = 12'h017;
  localparam logic [11:0] E5   = 12'h005;
  localparam logic [11:0] E47  = 12'h047;
`endif

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // accept v, run 8 shift edges, check result, drain with out_ready=1
  task automatic convert(input string tag, input logic [7:0] v,
                         input logic [11:0] exp);
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    in       = v;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    repeat (7) step();
    chk({tag, "_early"}, 32'(out_valid), 32'd0);
    step();
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_out"}, 32'(out), 32'(exp));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_drain"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [11:0] held;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in        = 8'd0;
    out_ready = 1'b0;
    repeat (2) step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    #2 rst_n = 1'b1;
    step();
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    convert("zero", 8'd0, E0);
    convert("max", 8'd255, E255);
    convert("nine", 8'd9, E9);
    convert("hundred", 8'd100, E100);
    convert("fortyseven", 8'd47, E47);

    // backpressure: hold out_ready low for 5 cycles in DONE
    in       = 8'd99;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (8) step();
    chk("bp_vld", 32'(out_valid), 32'd1);
    chk("bp_out", 32'(out), 32'(E99));
    held = out;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_vld", 32'(out_valid), 32'd1);
      chk("bp_hold_out", 32'(out), 32'(held));
      chk("bp_hold_rdy", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_release", 32'(out_valid), 32'd0);

    // in_valid held high with another word during a conversion
    in       = 8'd42;
    in_valid = 1'b1;
    step();
    in = 8'd17;
    repeat (8) step();
    chk("ign_vld", 32'(out_valid), 32'd1);
    chk("ign_out", 32'(out), 32'(E42));
    out_ready = 1'b1;
    step();
    chk("ign_idle", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("ign_accept", 32'(busy), 32'd1);
    chk("ign_accept_rdy", 32'(in_ready), 32'd0);
    repeat (7) step();
    chk("ign2_early", 32'(out_valid), 32'd0);
    step();
    chk("ign2_vld", 32'(out_valid), 32'd1);
    chk("ign2_out", 32'(out), 32'(E17));
    step();
    out_ready = 1'b0;
    chk("ign2_drain", 32'(out_valid), 32'd0);

    // async reset mid-conversion
    in       = 8'd200;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(out_valid), 32'd0);
    chk("mid_rst_out", 32'(out), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rdy", 32'(in_ready), 32'd0);
    #1 rst_n = 1'b1;
    #1;
    chk("mid_rel_rdy", 32'(in_ready), 32'd1);
    chk("mid_rel_vld", 32'(out_valid), 32'd0);
    step();
    convert("five", 8'd5, E5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
